// File: rtl/conv_ser_feeder_16_if.sv
// conv_ser_feeder_16_if
// Bundles the word-input handshake and the pair-output bus of the
// serializer feeder.
//   IN_DATA/IN_VALID/IN_READY : word input. A word transfers at a rising
//                               edge where IN_VALID and IN_READY are both 1.
//                               IN_READY does not depend on IN_VALID.
//   PAR_OUT1/PAR_OUT2         : even/odd bit of the current pair.
//   OUT_ACTIVE/WORD_START     : pair carries data / pair is pair 0 of a word.
//   UNDERRUN                  : one-cycle pulse when the stream goes idle.
//   LEVEL                     : words held in the FIFO.
//   dbg_shift/dbg_k           : shifter state (1 = SHIFT) and pair counter.
// slave modport is the feeder, master modport is the word producer.
interface conv_ser_feeder_16_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(WIDTH / 2);

  logic [WIDTH-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic             PAR_OUT1;
  logic             PAR_OUT2;
  logic             OUT_ACTIVE;
  logic             WORD_START;
  logic             UNDERRUN;
  logic [LW-1:0]    LEVEL;
  logic             dbg_shift;
  logic [KW-1:0]    dbg_k;

  modport slave (
    input  IN_DATA, IN_VALID,
    output IN_READY, PAR_OUT1, PAR_OUT2, OUT_ACTIVE, WORD_START, UNDERRUN,
           LEVEL, dbg_shift, dbg_k
  );

  modport master (
    output IN_DATA, IN_VALID,
    input  IN_READY, PAR_OUT1, PAR_OUT2, OUT_ACTIVE, WORD_START, UNDERRUN,
           LEVEL, dbg_shift, dbg_k
  );
endinterface

// File: rtl/conv_ser_feeder_16.sv
// conv_ser_feeder_16
// Buffers parallel words in a small FIFO and feeds them two bits per cycle
// (LSB pair first) to a downstream 2:1 serializer, back-to-back with no
// gap between words while the FIFO has data.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : conv_ser_feeder_16_if.slave (word input, pair output, level,
//          debug view of the shifter state and pair counter)
module conv_ser_feeder_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic                 CLK,
  input logic                 RST,
  conv_ser_feeder_16_if.slave bus
);
  localparam int NP = WIDTH / 2;
  localparam int KW = $clog2(NP);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             word_start_q, word_start_d;
  logic             underrun_q, underrun_d;
  logic [LW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic in_ready;
  logic push;
  logic pop;
  logic not_empty;
  logic last_pair;

  // Ready comes only from the registered count, so a pop in the same cycle
  // never opens room for a push into a full FIFO.
  assign in_ready  = (count_q < LW'(DEPTH));
  assign push      = bus.IN_VALID & in_ready;
  assign not_empty = (count_q != '0);
  assign last_pair = (k_q == KW'(NP - 1));
  assign pop       = not_empty &
                     ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & last_pair));

  // State register (and all other flops).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      shreg_q      <= '0;
      word_start_q <= 1'b0;
      underrun_q   <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      shreg_q      <= shreg_d;
      word_start_q <= word_start_d;
      underrun_q   <= underrun_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.IN_DATA;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (not_empty) state_d = ST_SHIFT;
      ST_SHIFT: if (last_pair && !not_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    k_d          = k_q;
    shreg_d      = shreg_q;
    word_start_d = 1'b0;
    underrun_d   = 1'b0;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + LW'(push) - LW'(pop);
    if (pop) begin
      shreg_d      = mem_q[rd_ptr_q];
      k_d          = '0;
      word_start_d = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (last_pair) begin
        // Clearing the shifter keeps the pair outputs at zero in IDLE.
        shreg_d    = '0;
        k_d        = '0;
        underrun_d = 1'b1;
      end else begin
        shreg_d = shreg_q >> 2;
        k_d     = k_q + KW'(1);
      end
    end
  end

  // The current pair always sits in the two LSBs of the shifter.
  assign bus.IN_READY   = in_ready;
  assign bus.PAR_OUT1   = shreg_q[0];
  assign bus.PAR_OUT2   = shreg_q[1];
  assign bus.OUT_ACTIVE = (state_q == ST_SHIFT);
  assign bus.WORD_START = word_start_q;
  assign bus.UNDERRUN   = underrun_q;
  assign bus.LEVEL      = count_q;
  assign bus.dbg_shift  = (state_q == ST_SHIFT);
  assign bus.dbg_k      = k_q;
endmodule
